// File: rtl/csi2_tx_line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : csi2_tx_line_buffer
// Purpose  : Captures one RAW pixel line at a time from an AXI-Stream video
//            source into a line RAM and replays it to the CSI-2 packetizer
//            with line framing. Produces the frame start / active / done
//            handshake used by the CSI-2 TX frame controller.
// Ports    : clk, rst                 - clock, synchronous active-high reset
//            capture_enable           - arm a frame capture (sampled in IDLE)
//            s_tdata/s_tvalid/s_tready/s_tuser/s_tlast - source stream
//            m_tdata/m_tvalid/m_tready/m_tlast         - replay stream
//            m_line_len               - word count of the line being replayed
//            frame_start_pulse, frame_active, frame_done_pulse - frame status
//            overflow_err             - pulse when a line exceeds LINE_WORDS
// Revision : 1.0 - initial release
// ============================================================================
module csi2_tx_line_buffer #(
    parameter int DATA_W      = 16,
    parameter int LINE_WORDS  = 2048,
    parameter int ADDR_W      = 11,
    parameter int FRAME_LINES = 1080
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              capture_enable,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tvalid,
    output logic              s_tready,
    input  logic              s_tuser,
    input  logic              s_tlast,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast,
    output logic [ADDR_W:0]   m_line_len,
    output logic              frame_start_pulse,
    output logic              frame_active,
    output logic              frame_done_pulse,
    output logic              overflow_err
);

    localparam int c_LC_W = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;
    localparam logic [c_LC_W-1:0] c_LAST_LINE = c_LC_W'(FRAME_LINES - 1);
    localparam logic [c_LC_W-1:0] c_LC_ONE    = c_LC_W'(1);
    localparam logic [ADDR_W-1:0] c_ADDR_MAX  = ADDR_W'(LINE_WORDS - 1);
    localparam logic [ADDR_W-1:0] c_ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   c_LEN_ONE   = (ADDR_W + 1)'(1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_SOF = 3'd1,
        ST_CAPTURE  = 3'd2,
        ST_DISCARD  = 3'd3,
        ST_REPLAY   = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic [DATA_W-1:0]   r_mem [LINE_WORDS];

    logic [ADDR_W-1:0]   r_wr_addr;
    logic [c_LC_W-1:0]   r_line_cnt;
    logic [ADDR_W:0]     r_len;
    logic                r_fs_pulse;
    logic                r_fd_pulse;
    logic                r_ovf_pulse;
    logic                r_active;

    // Replay pipeline: read pointer, one RAM read in flight, output register
    // and a skid register that absorbs the in-flight word when m_tready drops.
    logic [ADDR_W:0]     r_rd_ptr;
    logic                r_inflight;
    logic                r_inflight_last;
    logic [DATA_W-1:0]   r_rd_data;
    logic                r_skid_v;
    logic                r_skid_last;
    logic [DATA_W-1:0]   r_skid_data;
    logic                r_out_v;
    logic                r_out_last;
    logic [DATA_W-1:0]   r_out_data;

    logic                w_s_ready;
    logic                w_accept;
    logic                w_wr_en;
    logic [ADDR_W-1:0]   w_wr_addr;
    logic                w_sof;
    logic                w_ovf;
    logic                w_hs;
    logic                w_line_done;
    logic                w_frame_last;
    logic [1:0]          w_occ;
    logic                w_issue;

    assign w_s_ready    = (r_state != ST_REPLAY);
    assign w_accept     = s_tvalid & w_s_ready;
    assign w_hs         = r_out_v & m_tready;
    assign w_line_done  = w_hs & r_out_last;
    assign w_frame_last = (r_line_cnt == c_LAST_LINE);

    // Words held or on their way: at most two, so a read is only issued when
    // the skid register is guaranteed to have room for its result.
    assign w_occ   = 2'(r_out_v) + 2'(r_skid_v) + 2'(r_inflight);
    assign w_issue = (r_state == ST_REPLAY) && (r_rd_ptr < r_len) &&
                     ((w_occ - 2'(w_hs)) < 2'd2);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and capture control
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_wr_en      = 1'b0;
        w_wr_addr    = r_wr_addr;
        w_sof        = 1'b0;
        w_ovf        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (capture_enable) begin
                    w_next_state = ST_WAIT_SOF;
                end
            end
            ST_WAIT_SOF: begin
                if (w_accept && s_tuser) begin
                    w_wr_en      = 1'b1;
                    w_wr_addr    = '0;
                    w_sof        = 1'b1;
                    w_next_state = s_tlast ? ST_REPLAY : ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (w_accept) begin
                    w_wr_en = 1'b1;
                    if (s_tlast) begin
                        w_next_state = ST_REPLAY;
                    end else if (r_wr_addr == c_ADDR_MAX) begin
                        w_ovf        = 1'b1;
                        w_next_state = ST_DISCARD;
                    end
                end
            end
            ST_DISCARD: begin
                if (w_accept && s_tlast) begin
                    w_next_state = ST_REPLAY;
                end
            end
            ST_REPLAY: begin
                if (w_line_done) begin
                    w_next_state = w_frame_last ? ST_IDLE : ST_CAPTURE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Line RAM: one write port (capture), one registered read port (replay)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= s_tdata;
        end
        if (w_issue) begin
            r_rd_data <= r_mem[r_rd_ptr[ADDR_W-1:0]];
        end
    end

    // ------------------------------------------------------------------
    // Capture bookkeeping, frame status and replay pipeline
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_addr       <= '0;
            r_line_cnt      <= '0;
            r_len           <= '0;
            r_fs_pulse      <= 1'b0;
            r_fd_pulse      <= 1'b0;
            r_ovf_pulse     <= 1'b0;
            r_active        <= 1'b0;
            r_rd_ptr        <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_skid_v        <= 1'b0;
            r_skid_last     <= 1'b0;
            r_skid_data     <= '0;
            r_out_v         <= 1'b0;
            r_out_last      <= 1'b0;
            r_out_data      <= '0;
        end else begin
            r_fs_pulse  <= w_sof;
            r_ovf_pulse <= w_ovf;
            r_fd_pulse  <= w_line_done & w_frame_last;

            // Active from the start pulse through the done pulse inclusive.
            if (w_sof) begin
                r_active <= 1'b1;
            end else if (r_fd_pulse) begin
                r_active <= 1'b0;
            end

            if (w_wr_en) begin
                r_wr_addr <= w_wr_addr + c_ADDR_ONE;
                // On overflow w_wr_addr is LINE_WORDS-1, so this yields
                // LINE_WORDS, the number of words actually stored.
                if (s_tlast || w_ovf) begin
                    r_len <= {1'b0, w_wr_addr} + c_LEN_ONE;
                end
            end

            if (w_sof) begin
                r_line_cnt <= '0;
            end else if (w_line_done && !w_frame_last) begin
                r_line_cnt <= r_line_cnt + c_LC_ONE;
            end

            // RAM read issue
            if (w_issue) begin
                r_rd_ptr        <= r_rd_ptr + c_LEN_ONE;
                r_inflight      <= 1'b1;
                r_inflight_last <= ((r_rd_ptr + c_LEN_ONE) == r_len);
            end else begin
                r_inflight      <= 1'b0;
            end

            // Output / skid movement
            if (w_hs || !r_out_v) begin
                if (r_skid_v) begin
                    r_out_v    <= 1'b1;
                    r_out_data <= r_skid_data;
                    r_out_last <= r_skid_last;
                    if (r_inflight) begin
                        r_skid_data <= r_rd_data;
                        r_skid_last <= r_inflight_last;
                    end else begin
                        r_skid_v <= 1'b0;
                    end
                end else if (r_inflight) begin
                    r_out_v    <= 1'b1;
                    r_out_data <= r_rd_data;
                    r_out_last <= r_inflight_last;
                end else begin
                    r_out_v <= 1'b0;
                end
            end else if (r_inflight) begin
                r_skid_v    <= 1'b1;
                r_skid_data <= r_rd_data;
                r_skid_last <= r_inflight_last;
            end

            // End of line: nothing can remain in the pipe, but clear it so the
            // next replay always starts from a known state.
            if (w_line_done) begin
                r_wr_addr  <= '0;
                r_rd_ptr   <= '0;
                r_inflight <= 1'b0;
                r_skid_v   <= 1'b0;
                r_out_v    <= 1'b0;
                r_out_last <= 1'b0;
            end
        end
    end

    // Outputs are forced low while reset is asserted, before the state
    // register has had an edge to return to IDLE.
    assign s_tready          = w_s_ready & ~rst;
    assign m_tvalid          = r_out_v & ~rst;
    assign m_tdata           = rst ? '0 : r_out_data;
    assign m_tlast           = r_out_last & ~rst;
    assign m_line_len        = rst ? '0 : r_len;
    assign frame_start_pulse = r_fs_pulse & ~rst;
    assign frame_active      = r_active & ~rst;
    assign frame_done_pulse  = r_fd_pulse & ~rst;
    assign overflow_err      = r_ovf_pulse & ~rst;

endmodule
`default_nettype wire

// File: tb/tb_csi2_tx_line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_csi2_tx_line_buffer
// Purpose  : Scoreboard bench for csi2_tx_line_buffer (FRAME_LINES=3,
//            LINE_WORDS=8). Stimulus pushes the expected replay words of each
//            line; a monitor pops and compares on every output handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csi2_tx_line_buffer;

    localparam int DW = 16;
    localparam int LW = 8;
    localparam int AW = 3;
    localparam int FL = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          capture_enable;
    logic [DW-1:0] s_tdata;
    logic          s_tvalid;
    logic          s_tready;
    logic          s_tuser;
    logic          s_tlast;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic          m_tlast;
    logic [AW:0]   m_line_len;
    logic          frame_start_pulse;
    logic          frame_active;
    logic          frame_done_pulse;
    logic          overflow_err;

    csi2_tx_line_buffer #(
        .DATA_W(DW), .LINE_WORDS(LW), .ADDR_W(AW), .FRAME_LINES(FL)
    ) dut (
        .clk(clk), .rst(rst), .capture_enable(capture_enable),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .s_tuser(s_tuser), .s_tlast(s_tlast),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_tlast(m_tlast), .m_line_len(m_line_len),
        .frame_start_pulse(frame_start_pulse), .frame_active(frame_active),
        .frame_done_pulse(frame_done_pulse), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic [AW:0]   len;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   fs_cnt   = 0;
    int   fd_cnt   = 0;
    int   ovf_cnt  = 0;
    int   pop_cnt  = 0;
    int   ready_mode = 0;   // 0: m_tready always 1, 1: random 50%

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    logic          prev_done  = 1'b0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data  = '0;
    logic          prev_last  = 1'b0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_done  = 1'b0;
                prev_stall = 1'b0;
            end else begin
                if (frame_start_pulse) begin
                    fs_cnt++;
                    chk("active_at_start", 32'(frame_active), 32'd1);
                end
                if (frame_done_pulse) begin
                    fd_cnt++;
                    chk("active_at_done", 32'(frame_active), 32'd1);
                end
                if (prev_done) chk("active_after_done", 32'(frame_active), 32'd0);
                if (overflow_err) ovf_cnt++;
                if (m_tvalid) begin
                    chk("s_tready_in_replay", 32'(s_tready), 32'd0);
                    chk("active_in_replay", 32'(frame_active), 32'd1);
                end
                if (prev_stall) begin
                    chk("stall_valid", 32'(m_tvalid), 32'd1);
                    chk("stall_data", 32'(m_tdata), 32'(prev_data));
                    chk("stall_last", 32'(m_tlast), 32'(prev_last));
                end
                if (m_tvalid && m_tready) begin
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_output: got data 0x%0h, no word expected", m_tdata);
                    end else begin
                        e = sb_q.pop_front();
                        chk("out_data", 32'(m_tdata), 32'(e.data));
                        chk("out_last", 32'(m_tlast), 32'(e.last));
                        chk("out_len", 32'(m_line_len), 32'(e.len));
                        pop_cnt++;
                    end
                end
                prev_done  = frame_done_pulse;
                prev_stall = m_tvalid & ~m_tready;
                prev_data  = m_tdata;
                prev_last  = m_tlast;
            end
        end
    end

    // Downstream ready generator
    initial begin
        m_tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            m_tready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic send_beat(input logic [DW-1:0] d, input logic u, input logic l);
        int t = 0;
        s_tdata  = d;
        s_tuser  = u;
        s_tlast  = l;
        s_tvalid = 1'b1;
        @(negedge clk);
        while (!s_tready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (!s_tready) chk("src_accept_timeout", 32'(s_tready), 32'd1);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tuser  = 1'b0;
        s_tlast  = 1'b0;
    endtask

    // Expected replay: the first min(n, LINE_WORDS) words, last flag on the
    // final stored word, length equal to the stored word count.
    task automatic send_line(input logic [DW-1:0] words[$], input bit sof);
        int n = words.size();
        int k = (n > LW) ? LW : n;
        exp_t e;
        for (int i = 0; i < k; i++) begin
            e.data = words[i];
            e.last = (i == k - 1);
            e.len  = (AW + 1)'(k);
            sb_q.push_back(e);
        end
        for (int i = 0; i < n; i++) begin
            send_beat(words[i], sof && (i == 0), i == n - 1);
        end
    endtask

    task automatic arm();
        @(posedge clk);
        #1;
        capture_enable = 1'b1;
        @(posedge clk);
        #1;
        capture_enable = 1'b0;
    endtask

    task automatic wait_frame(input int fs0, input int fd0, input int ovf0,
                              input int ovf_exp);
        int t = 0;
        while (fd_cnt == fd0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        chk("frame_start_count", 32'(fs_cnt - fs0), 32'd1);
        chk("frame_done_count", 32'(fd_cnt - fd0), 32'd1);
        chk("overflow_count", 32'(ovf_cnt - ovf0), 32'(ovf_exp));
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        chk("active_idle", 32'(frame_active), 32'd0);
    endtask

    task automatic run_std_frame(input logic [DW-1:0] base);
        logic [DW-1:0] w[$];
        for (int ln = 0; ln < FL; ln++) begin
            w.delete();
            for (int i = 0; i < 5; i++) w.push_back(base + DW'(ln * 5 + i));
            send_line(w, ln == 0);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_s_tready"}, 32'(s_tready), 32'd0);
        chk({tag, "_m_tvalid"}, 32'(m_tvalid), 32'd0);
        chk({tag, "_m_tlast"}, 32'(m_tlast), 32'd0);
        chk({tag, "_m_tdata"}, 32'(m_tdata), 32'd0);
        chk({tag, "_m_line_len"}, 32'(m_line_len), 32'd0);
        chk({tag, "_pulses"}, {29'd0, frame_start_pulse, frame_done_pulse, overflow_err}, 32'd0);
        chk({tag, "_frame_active"}, 32'(frame_active), 32'd0);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int fs0, fd0, ovf0, p0, t;
        logic [DW-1:0] w[$];

        rst = 1'b1;
        capture_enable = 1'b0;
        s_tdata = '0; s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_s_tready", 32'(s_tready), 32'd1);
        chk("idle_active", 32'(frame_active), 32'd0);

        // Beats dropped in IDLE, then in WAIT_SOF, then a 3x5 frame.
        fs0 = fs_cnt; fd0 = fd_cnt; ovf0 = ovf_cnt;
        @(posedge clk); #1;
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) arm();
            for (int i = 0; i < 4; i++) begin
                s_tdata = 16'hDEAD; s_tvalid = 1'b1;
                @(negedge clk);
                chk("drop_s_tready", 32'(s_tready), 32'd1);
                chk("drop_m_tvalid", 32'(m_tvalid), 32'd0);
                @(posedge clk); #1;
                s_tvalid = 1'b0;
            end
        end
        run_std_frame(16'h0100);
        wait_frame(fs0, fd0, ovf0, 0);

        // Same frame with random back-pressure.
        ready_mode = 1;
        fs0 = fs_cnt; fd0 = fd_cnt; ovf0 = ovf_cnt;
        arm();
        run_std_frame(16'h0100);
        wait_frame(fs0, fd0, ovf0, 0);

        // Overflow: 10-word first line keeps only 8 words.
        fs0 = fs_cnt; fd0 = fd_cnt; ovf0 = ovf_cnt;
        arm();
        w.delete();
        for (int i = 0; i < 10; i++) w.push_back(16'h0200 + DW'(i));
        send_line(w, 1'b1);
        for (int ln = 1; ln < FL; ln++) begin
            w.delete();
            for (int i = 0; i < 5; i++) w.push_back(16'h0210 + DW'(ln * 5 + i));
            send_line(w, 1'b0);
        end
        wait_frame(fs0, fd0, ovf0, 1);

        // Single-word SOF line, then a full 8-word line, then a random one.
        fs0 = fs_cnt; fd0 = fd_cnt; ovf0 = ovf_cnt;
        arm();
        w.delete();
        w.push_back(DW'($urandom));
        send_line(w, 1'b1);
        w.delete();
        for (int i = 0; i < LW; i++) w.push_back(DW'($urandom));
        send_line(w, 1'b0);
        w.delete();
        for (int i = 0; i < int'($urandom_range(1, LW - 1)); i++) w.push_back(DW'($urandom));
        send_line(w, 1'b0);
        wait_frame(fs0, fd0, ovf0, 0);

        // Reset in the middle of replaying line 2.
        ready_mode = 0;
        fd0 = fd_cnt;
        p0  = pop_cnt;
        arm();
        for (int ln = 0; ln < 2; ln++) begin
            w.delete();
            for (int i = 0; i < 5; i++) w.push_back(16'h0400 + DW'(ln * 5 + i));
            send_line(w, ln == 0);
        end
        t = 0;
        while (pop_cnt < p0 + 7 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("midline_progress", 32'(pop_cnt >= p0 + 7), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("midreset");
        @(posedge clk); #1;
        rst = 1'b0;
        sb_q.delete();
        @(negedge clk);
        chk("post_reset_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("post_reset_active", 32'(frame_active), 32'd0);
        chk("post_reset_s_tready", 32'(s_tready), 32'd1);
        repeat (10) @(negedge clk);
        chk("no_done_after_reset", 32'(fd_cnt - fd0), 32'd0);

        fs0 = fs_cnt; fd0 = fd_cnt; ovf0 = ovf_cnt;
        arm();
        run_std_frame(16'h0300);
        wait_frame(fs0, fd0, ovf0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
